reliable_sender: RTL and testbench
==================================

# reliable_sender

Transmit side of the reliable-data link. Accepts one payload word at a time and wraps it in a frame: a 1-bit alternating sequence number, the payload, and an 8-bit check field. It presents the frame to the channel and waits for an ACK/NAK from the receiver, retransmitting on NAK or timeout up to a bounded retry count. It sits between the data source and the channel/receiver, and generalises the fixed-width sender to configurable width, timeout and retry policy.

## Interface
- DATA_W, 16, payload width in bits; must be a multiple of 8, minimum 8.
- TIMEOUT, 8, number of WAIT_ACK cycles without a valid ACK/NAK before a retransmit; minimum 2.
- MAX_RETRY, 2, number of retransmissions allowed after the first send.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  source offers a payload.
- in_data  in  DATA_W  payload.
- in_ready  out  1  sender can accept a payload.
- tx_valid  out  1  frame on tx_frame is valid.
- tx_frame  out  DATA_W+9  frame laid out as {seq, payload, chk}, with seq in the MSB.
- tx_ready  in  1  channel accepts the frame.
- ack_valid  in  1  receiver response is present.
- ack_nak  in  1  1 = NAK, 0 = ACK.
- ack_seq  in  1  sequence number the response refers to.
- done  out  1  one-cycle pulse: frame acknowledged.
- fail  out  1  one-cycle pulse: retries exhausted, frame dropped.
- retry_cnt  out  $clog2(MAX_RETRY+1)  retransmissions of the current frame so far.

## Operation
- The block is an FSM with four states: IDLE, SEND, WAIT_ACK, REPORT.
- **IDLE**
  - in_ready=1.
  - on in_valid: latch in_data, latch chk, clear retry_cnt, go to SEND.
- **SEND**
  - tx_valid=1; tx_frame is held stable while tx_ready=0.
  - on tx_ready: clear the timer, go to WAIT_ACK.
- **WAIT_ACK**
  - The timer increments every cycle.
  - ACK, i.e. ack_valid & !ack_nak & ack_seq==seq: toggle seq, set done, go to REPORT.
  - NAK with ack_seq==seq, or timer==TIMEOUT-1: the frame must be resent.
    - If retry_cnt<MAX_RETRY: increment retry_cnt, go to SEND.
    - Otherwise: set fail, toggle seq, go to REPORT.
  - A response with ack_seq!=seq is a stale duplicate: ignore it, and the timer keeps running.
- **REPORT**
  - done/fail are high for this single cycle; in_ready=0.
  - Next state is IDLE.
- Simultaneous events:
  - An ACK in the same cycle as timer expiry: the ACK wins.
  - A NAK in the same cycle as timer expiry counts as one retry, not two.
- ack_valid is ignored outside WAIT_ACK.
- chk is computed once at accept time over payload bytes, MSB byte first; seq is not covered.
- Reset mid-operation: the current frame is abandoned with no done/fail pulse; seq returns to 0.

## Timing
- Reset values:
  - state=IDLE, seq=0, retry_cnt=0, timer=0.
  - in_ready=1, tx_valid=0, tx_frame=0, done=0, fail=0.
- All outputs are registered or decoded directly from the state register; there is no combinational path from any input to any output.
- Payload accepted in cycle N gives tx_valid=1 in cycle N+1.
- tx handshake in cycle M: the first possible ACK is sampled in cycle M+1.
- With no response, the retransmit tx_valid rises in cycle M+TIMEOUT+1.
- ACK sampled in cycle K: done=1 in cycle K+1, in_ready=1 in cycle K+2.
- Back-to-back throughput is at best one frame per 4 cycles.

## Configuration
- RELIABLE_SENDER_CRC_EN defined: chk = CRC-8.
  - Polynomial 0x07, init 0x00, no reflection, no final XOR.
  - Input is processed MSB first across all payload bytes.
- RELIABLE_SENDER_CRC_EN undefined: chk = XOR of all payload bytes (longitudinal parity).
- The frame width is identical in both builds.

## Structure
- Shared package reliable_pkg holds:
  - state enum: IDLE, SEND, WAIT_ACK, REPORT.
  - CHK_W=8.
  - CRC_POLY=8'h07.
  - frame field offset helpers, shared with the receiver.
- Sub-module reliable_chk: combinational, parameter DATA_W, input payload, output 8-bit chk; contains the macro selection. It is reused by the receiver for checking.

## Test plan
All scenarios use DATA_W=16, TIMEOUT=8, MAX_RETRY=2.
- **Clean ACK:** send 0x1234 with tx_ready=1, then ACK with seq=0 one cycle later.
  - Expected: tx_frame={0,0x1234,0x26} (XOR build), done pulse once, next frame carries seq=1.
- **CRC build:** send 0x0001.
  - Expected: chk=0x07 with the macro defined, 0x01 without it.
- **NAK then ACK:** NAK with seq=0, then ACK.
  - Expected: the same frame is resent, retry_cnt=1, then done.
- **Timeout exhaustion:** never respond.
  - Expected: 3 transmissions each 9 cycles apart (TIMEOUT+1), then a fail pulse, retry_cnt=2 at fail, and the next frame uses seq=1.
- **Stale ACK and backpressure:**
  - ACK with seq=1 while waiting on seq=0: ignored, and the timeout still fires at 8 cycles.
  - Hold tx_ready=0 for 5 cycles: tx_frame stays stable and the timer does not run.
- **Reset mid-WAIT_ACK:** assert rst, then release it.
  - Expected: all outputs at their reset values, no done/fail pulse, seq=0 on the next frame.

Source files
------------

// File: rtl/reliable_pkg.sv
// rtl/reliable_pkg.sv - shared types and frame layout helpers for the reliable-data link
//
// Purpose: state encoding, check-field constants and frame field offsets
//          used by both the sender and the receiver.
// Ports:   none (package).
package reliable_pkg;

    localparam int CHK_W = 8;
    localparam logic [CHK_W-1:0] CRC_POLY = 8'h07;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_ACK = 2'd2,
        REPORT   = 2'd3
    } state_t;

    // Frame layout: {seq, payload, chk}, seq in the MSB.
    function automatic int frame_w(input int data_w);
        return data_w + CHK_W + 1;
    endfunction

    function automatic int seq_pos(input int data_w);
        return data_w + CHK_W;
    endfunction

    function automatic int payload_lsb();
        return CHK_W;
    endfunction

endpackage

// File: rtl/reliable_chk.sv
// rtl/reliable_chk.sv - combinational 8-bit check field over a payload
//
// Purpose: computes the frame check field, MSB byte first. Build option
//          RELIABLE_SENDER_CRC_EN selects CRC-8 (poly 0x07, init 0, no
//          reflection, no final XOR); otherwise XOR of all payload bytes.
// Ports:   payload [DATA_W-1:0] in  - payload word (DATA_W multiple of 8)
//          chk     [7:0]        out - check field
module reliable_chk
    import reliable_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] payload,
    output logic [CHK_W-1:0]  chk
);

`ifdef RELIABLE_SENDER_CRC_EN
    logic [CHK_W-1:0] crc;
    logic             fb;

    // Bit-serial CRC unrolled over the whole word; MSB of the word is the
    // MSB of the first byte, so walking bits high to low is byte order too.
    always_comb begin
        crc = '0;
        fb  = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb  = crc[CHK_W-1] ^ payload[i];
            crc = {crc[CHK_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
        end
        chk = crc;
    end
`else
    always_comb begin
        chk = '0;
        for (int i = 0; i < DATA_W / 8; i++) begin
            chk = chk ^ payload[i*8 +: 8];
        end
    end
`endif

endmodule

// File: rtl/reliable_sender.sv
// rtl/reliable_sender.sv - transmit side of the reliable-data link (stop-and-wait ARQ)
//
// Purpose: frames one payload as {seq, payload, chk}, sends it, waits for
//          ACK/NAK and retransmits on NAK or timeout up to MAX_RETRY times.
//          Check field type follows build option RELIABLE_SENDER_CRC_EN.
// Ports:   clk, rst (async, active high)
//          in_valid/in_data/in_ready        - payload input
//          tx_valid/tx_frame/tx_ready       - frame output to channel
//          ack_valid/ack_nak/ack_seq        - receiver response
//          done/fail                        - one-cycle result pulses
//          retry_cnt                        - retransmissions of current frame
module reliable_sender
    import reliable_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int TIMEOUT   = 8,
    parameter int MAX_RETRY = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    input  logic [DATA_W-1:0]                  in_data,
    output logic                               in_ready,
    output logic                               tx_valid,
    output logic [frame_w(DATA_W)-1:0]         tx_frame,
    input  logic                               tx_ready,
    input  logic                               ack_valid,
    input  logic                               ack_nak,
    input  logic                               ack_seq,
    output logic                               done,
    output logic                               fail,
    output logic [$clog2(MAX_RETRY+1)-1:0]     retry_cnt
);

    localparam int RC_W = $clog2(MAX_RETRY + 1);
    localparam int TM_W = $clog2(TIMEOUT);

    state_t            state, state_n;
    logic              seq;
    logic [DATA_W-1:0] payload_q;
    logic [CHK_W-1:0]  chk_q, chk_w;
    logic [RC_W-1:0]   retry_q;
    logic [TM_W-1:0]   timer_q;
    logic              ok_q;

    logic accept, resend, finish_ok, finish_fail;
    logic resp_match, expired;

    reliable_chk #(.DATA_W(DATA_W)) u_chk (
        .payload (in_data),
        .chk     (chk_w)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // ACK is tested first so it beats a same-cycle expiry; NAK and expiry
    // share one branch so together they cost a single retry.
    always_comb begin
        state_n     = state;
        accept      = 1'b0;
        resend      = 1'b0;
        finish_ok   = 1'b0;
        finish_fail = 1'b0;
        resp_match  = ack_valid && (ack_seq == seq);
        expired     = (timer_q == TM_W'(TIMEOUT - 1));
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (tx_ready) state_n = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (resp_match && !ack_nak) begin
                    finish_ok = 1'b1;
                    state_n   = REPORT;
                end else if ((resp_match && ack_nak) || expired) begin
                    if (retry_q < RC_W'(MAX_RETRY)) begin
                        resend  = 1'b1;
                        state_n = SEND;
                    end else begin
                        finish_fail = 1'b1;
                        state_n     = REPORT;
                    end
                end
            end
            REPORT:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq       <= 1'b0;
            payload_q <= '0;
            chk_q     <= '0;
            retry_q   <= '0;
            timer_q   <= '0;
            ok_q      <= 1'b0;
        end else begin
            if (accept) begin
                payload_q <= in_data;
                chk_q     <= chk_w;
                retry_q   <= '0;
            end
            if (resend) retry_q <= retry_q + 1'b1;
            if (finish_ok || finish_fail) begin
                seq  <= ~seq;
                ok_q <= finish_ok;
            end
            // Held at zero outside WAIT_ACK, so backpressure in SEND never
            // eats into the response window.
            if (state == WAIT_ACK) timer_q <= timer_q + 1'b1;
            else                   timer_q <= '0;
        end
    end

    assign in_ready  = (state == IDLE);
    assign tx_valid  = (state == SEND);
    assign tx_frame  = {seq, payload_q, chk_q};
    assign done      = (state == REPORT) && ok_q;
    assign fail      = (state == REPORT) && !ok_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_reliable_sender.sv
// tb/tb_reliable_sender.sv - self-checking bench for reliable_sender
module tb_reliable_sender;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [15:0] in_data;
    logic        tx_valid, tx_ready;
    logic [24:0] tx_frame;
    logic        ack_valid, ack_nak, ack_seq;
    logic        done, fail;
    logic [1:0]  retry_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic exp_seq = 1'b0;

    reliable_sender #(.DATA_W(16), .TIMEOUT(8), .MAX_RETRY(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .tx_valid  (tx_valid),
        .tx_frame  (tx_frame),
        .tx_ready  (tx_ready),
        .ack_valid (ack_valid),
        .ack_nak   (ack_nak),
        .ack_seq   (ack_seq),
        .done      (done),
        .fail      (fail),
        .retry_cnt (retry_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] payload;
        logic        nak_first;
        logic [7:0]  chk;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Next negedge must find the DUT in IDLE; returns at the negedge of the
    // first SEND cycle (tx handshake happens there when tx_ready=1).
    task automatic offer(input logic [15:0] p);
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        in_data  = p;
        @(negedge clk);
        in_valid = 1'b0;
        check("tx_valid_send", tx_valid, 1);
    endtask

    // Drive one response for a single cycle; returns one negedge later.
    task automatic respond(input logic nak, input logic s);
        ack_valid = 1'b1;
        ack_nak   = nak;
        ack_seq   = s;
        @(negedge clk);
        ack_valid = 1'b0;
    endtask

    task automatic wait_tx(output int n);
        n = 0;
        while (!tx_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!tx_valid) check("wait_tx_timeout", 0, 1);
    endtask

    task automatic expect_done();
        check("done", done, 1);
        check("fail_low", fail, 0);
        check("in_ready_report", in_ready, 0);
        exp_seq = ~exp_seq;
    endtask

    initial begin
        int t0, n, tx_seen, fail_t, fail_rc;
        int tx_t[3];
        logic [24:0] f0;
        logic saw_done;

        vecs[0] = '{16'h1234, 1'b0, 8'h26};
        vecs[1] = '{16'h0001, 1'b1, 8'h01};
        vecs[2] = '{16'hFFFF, 1'b0, 8'h00};
        vecs[3] = '{16'h00A5, 1'b1, 8'hA5};
`ifdef RELIABLE_SENDER_CRC_EN
        vecs[0].chk = 8'hF1;
        vecs[1].chk = 8'h07;
        vecs[2].chk = 8'h24;
        vecs[3].chk = 8'h72;
`endif

        rst = 1'b1; in_valid = 0; in_data = '0; tx_ready = 1'b1;
        ack_valid = 0; ack_nak = 0; ack_seq = 0;
        @(negedge clk); @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_frame", tx_frame, 0);
        check("rst_done", done, 0);
        check("rst_fail", fail, 0);
        check("rst_retry", retry_cnt, 0);
        rst = 1'b0;

        // Table-driven: clean ACK and NAK-then-ACK frames
        for (int i = 0; i < 4; i++) begin
            offer(vecs[i].payload);
            check("frame", tx_frame, {exp_seq, vecs[i].payload, vecs[i].chk});
            @(negedge clk);
            if (vecs[i].nak_first) begin
                respond(1'b1, exp_seq);
                check("resend_valid", tx_valid, 1);
                check("resend_frame", tx_frame, {exp_seq, vecs[i].payload, vecs[i].chk});
                check("retry_after_nak", retry_cnt, 1);
                @(negedge clk);
            end
            respond(1'b0, exp_seq);
            expect_done();
        end

        // Timeout exhaustion: three sends 9 cycles apart, then fail
        offer(16'hBEEF);
        t0 = cyc; tx_seen = 0; fail_t = -1; fail_rc = -1; saw_done = 1'b0;
        for (int i = 0; i < 40 && fail_t < 0; i++) begin
            if (tx_valid && tx_seen < 3) begin tx_t[tx_seen] = cyc - t0; tx_seen++; end
            if (fail) begin fail_t = cyc - t0; fail_rc = retry_cnt; end
            if (done) saw_done = 1'b1;
            if (fail_t < 0) @(negedge clk);
        end
        check("to_tx_count", tx_seen, 3);
        check("to_tx1", tx_t[1], 9);
        check("to_tx2", tx_t[2], 18);
        check("to_fail_time", fail_t, 27);
        check("to_fail_retry", fail_rc, 2);
        check("to_no_done", saw_done, 0);
        exp_seq = ~exp_seq;

        offer(16'h4321);
        check("seq_after_fail", tx_frame[24], exp_seq);
        @(negedge clk);
        respond(1'b0, exp_seq);
        expect_done();

        // Stale ACK ignored, timeout still fires after 8 WAIT cycles
        offer(16'h5A5A);
        t0 = cyc;
        @(negedge clk);
        respond(1'b0, ~exp_seq);
        check("stale_no_done", done, 0);
        wait_tx(n);
        check("stale_retx_time", cyc - t0, 9);
        check("stale_retry", retry_cnt, 1);
        @(negedge clk);
        respond(1'b0, exp_seq);
        expect_done();

        // Backpressure: frame stable for 5 cycles, timer idle
        tx_ready = 1'b0;
        offer(16'h0F0F);
        f0 = tx_frame;
        check("bp_seq", f0[24], exp_seq);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", tx_valid, 1);
            check("bp_stable", tx_frame, f0);
            @(negedge clk);
        end
        tx_ready = 1'b1;
        t0 = cyc;
        @(negedge clk);
        wait_tx(n);
        check("bp_retx_time", cyc - t0, 9);
        @(negedge clk);
        respond(1'b0, exp_seq);
        expect_done();

        // NAK coincident with expiry costs one retry; ACK at expiry wins
        offer(16'hC3C3);
        repeat (8) @(negedge clk);
        respond(1'b1, exp_seq);
        check("nak_expiry_resend", tx_valid, 1);
        check("nak_expiry_retry", retry_cnt, 1);
        repeat (8) @(negedge clk);
        respond(1'b0, exp_seq);
        check("ack_expiry_no_tx", tx_valid, 0);
        expect_done();

        // Reset in WAIT_ACK abandons the frame silently
        offer(16'h1111);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_tx_valid", tx_valid, 0);
        check("mid_rst_tx_frame", tx_frame, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_fail", fail, 0);
        check("mid_rst_retry", retry_cnt, 0);
        rst = 1'b0;
        exp_seq = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_quiet", {done, fail}, 0);
        end
        offer(16'h2222);
        check("post_rst_seq", tx_frame[24], 0);
        @(negedge clk);
        respond(1'b0, exp_seq);
        expect_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
